// File: rtl/wall_probe_sched.sv
// wall_probe_sched: one wall-ROM row port shared by four direction probes
// (0=left, 1=right, 2=up, 3=down) under round-robin arbitration. Each probe
// reports whether the column/row adjacent to the SIZE x SIZE ball touches a wall.
//
// state  | meaning
// IDLE   | waiting for a request; grants, latches ball position, edge pre-check
// ISSUE  | rom_rd strobe for the current row
// WAIT   | extra ROM latency cycles (only when ROM_LAT > 1)
// CHECK  | rom_data valid; evaluate hit, advance row or finish
// DONE   | done pulse, result already in blocked, advance rr pointer
module wall_probe_sched #(
  parameter int SIZE    = 16,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int ROM_LAT = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       BallX,
  input  logic [9:0]       BallY,
  input  logic [3:0]       req,
  output logic [3:0]       done,
  output logic [3:0]       blocked,
  output logic             busy,
  output logic             rom_rd,
  output logic [9:0]       rom_addr,
  input  logic [WIDTH-1:0] rom_data
);

  localparam int          CW        = $clog2(WIDTH);
  localparam logic [10:0] SIZE_W    = 11'(SIZE);
  localparam logic [10:0] WIDTH_W   = 11'(WIDTH);
  localparam logic [10:0] HEIGHT_W  = 11'(HEIGHT);
  localparam int          WAIT_INIT = (ROM_LAT > 1) ? ROM_LAT - 2 : 0;
  localparam int          WCW       = (WAIT_INIT > 0) ? $clog2(WAIT_INIT + 1) : 1;

  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t         state_q;
  logic [1:0]     dir_q;
  logic [1:0]     rr_q;
  logic [10:0]    row_q;
  logic [10:0]    row_end_q;
  logic [10:0]    col_q;
  logic [WCW-1:0] wait_q;
  logic [3:0]     done_q;
  logic [3:0]     blocked_q;
  logic           busy_q;
  logic           rom_rd_q;
  logic [9:0]     rom_addr_q;

  logic           gnt_vld_d;
  logic [1:0]     gnt_dir_d;
  logic [1:0]     idx;
  logic [10:0]    bx_w;
  logic [10:0]    by_w;
  logic           edge_d;
  logic [10:0]    row_start_d;
  logic [10:0]    row_end_d;
  logic [10:0]    col_d;
  logic           hit_d;
  logic           chk_fin_d;
  logic           chk_res_d;

  assign bx_w = {1'b0, BallX};
  assign by_w = {1'b0, BallY};

  // Round-robin grant: first requesting direction at or after rr_q (mod 4).
  // Scanning downwards lets the smallest offset win.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_dir_d = rr_q;
    idx       = rr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (req[idx]) begin
        gnt_vld_d = 1'b1;
        gnt_dir_d = idx;
      end
    end
  end

  // Probe geometry and screen-edge pre-check for the granted direction (11-bit sums).
  always_comb begin
    edge_d      = 1'b0;
    row_start_d = by_w;
    row_end_d   = by_w + SIZE_W - 11'd1;
    col_d       = bx_w;
    case (gnt_dir_d)
      DIR_L: begin
        edge_d = (bx_w == 11'd0) || (by_w >= HEIGHT_W);
        col_d  = bx_w - 11'd1;
      end
      DIR_R: begin
        edge_d = (bx_w + SIZE_W >= WIDTH_W) || (by_w >= HEIGHT_W);
        col_d  = bx_w + SIZE_W;
      end
      DIR_U: begin
        edge_d      = (by_w == 11'd0) || (by_w - 11'd1 >= HEIGHT_W);
        row_start_d = by_w - 11'd1;
        row_end_d   = by_w - 11'd1;
      end
      default: begin
        edge_d      = (by_w + SIZE_W >= HEIGHT_W);
        row_start_d = by_w + SIZE_W;
        row_end_d   = by_w + SIZE_W;
      end
    endcase
  end

  // Wall test on the returned row; columns beyond the ROM width count as wall.
  always_comb begin
    hit_d = 1'b0;
    if (!dir_q[1]) begin
      if (col_q >= WIDTH_W) hit_d = 1'b1;
      else                  hit_d = rom_data[col_q[CW-1:0]];
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (col_q + 11'(i) >= WIDTH_W)          hit_d = 1'b1;
        else if (rom_data[CW'(col_q + 11'(i))]) hit_d = 1'b1;
      end
    end
  end

  // CHECK decision: left/right exit early on a hit, on the last row, or when
  // the next row would fall below the screen (treated as wall).
  always_comb begin
    chk_fin_d = 1'b1;
    chk_res_d = hit_d;
    if (!dir_q[1] && !hit_d) begin
      if (row_q == row_end_q)                 chk_res_d = 1'b0;
      else if (row_q + 11'd1 >= HEIGHT_W)     chk_res_d = 1'b1;
      else                                    chk_fin_d = 1'b0;
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      dir_q      <= 2'd0;
      rr_q       <= 2'd0;
      row_q      <= '0;
      row_end_q  <= '0;
      col_q      <= '0;
      wait_q     <= '0;
      done_q     <= 4'b0000;
      blocked_q  <= 4'b0000;
      busy_q     <= 1'b0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            dir_q     <= gnt_dir_d;
            row_q     <= row_start_d;
            row_end_q <= row_end_d;
            col_q     <= col_d;
            busy_q    <= 1'b1;
            if (edge_d) begin
              state_q              <= S_DONE;
              done_q               <= 4'b0001 << gnt_dir_d;
              blocked_q[gnt_dir_d] <= 1'b1;
            end else begin
              state_q    <= S_ISSUE;
              rom_rd_q   <= 1'b1;
              rom_addr_q <= row_start_d[9:0];
            end
          end
        end
        S_ISSUE: begin
          rom_rd_q <= 1'b0;
          if (ROM_LAT > 1) begin
            state_q <= S_WAIT;
            wait_q  <= WCW'(WAIT_INIT);
          end else begin
            state_q <= S_CHECK;
          end
        end
        S_WAIT: begin
          if (wait_q == '0) state_q <= S_CHECK;
          else              wait_q  <= wait_q - 1'b1;
        end
        S_CHECK: begin
          if (chk_fin_d) begin
            state_q          <= S_DONE;
            done_q           <= 4'b0001 << dir_q;
            blocked_q[dir_q] <= chk_res_d;
          end else begin
            state_q    <= S_ISSUE;
            row_q      <= row_q + 11'd1;
            rom_rd_q   <= 1'b1;
            rom_addr_q <= row_q[9:0] + 10'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 4'b0000;
          busy_q  <= 1'b0;
          rr_q    <= dir_q + 2'd1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign blocked  = blocked_q;
  assign busy     = busy_q;
  assign rom_rd   = rom_rd_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_wall_probe_sched.sv
// Testbench for wall_probe_sched: two instances (ROM_LAT=1 and ROM_LAT=2)
// sharing one wall-map array, compared against a geometric reference model.
module tb_wall_probe_sched;

  localparam int SIZE   = 16;
  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [9:0]       bx       [2];
  logic [9:0]       by       [2];
  logic [3:0]       req      [2];
  logic [3:0]       done     [2];
  logic [3:0]       blocked  [2];
  logic             busy     [2];
  logic             rom_rd   [2];
  logic [9:0]       rom_addr [2];
  logic [WIDTH-1:0] rom_data [2];
  logic [WIDTH-1:0] mem      [HEIGHT];

  wall_probe_sched #(.SIZE(SIZE), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROM_LAT(1)) u_lat1 (
    .Clk(clk), .Reset(rst), .BallX(bx[0]), .BallY(by[0]), .req(req[0]),
    .done(done[0]), .blocked(blocked[0]), .busy(busy[0]),
    .rom_rd(rom_rd[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]));

  wall_probe_sched #(.SIZE(SIZE), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROM_LAT(2)) u_lat2 (
    .Clk(clk), .Reset(rst), .BallX(bx[1]), .BallY(by[1]), .req(req[1]),
    .done(done[1]), .blocked(blocked[1]), .busy(busy[1]),
    .rom_rd(rom_rd[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]));

  function automatic logic [WIDTH-1:0] rd_mem(input logic [9:0] a);
    if (int'(a) < HEIGHT) return mem[a];
    return '0;
  endfunction

  // ROM models: one and two cycles of read latency
  logic [9:0] a2_q;
  logic       v2_q;
  always @(posedge clk) begin
    if (rom_rd[0]) rom_data[0] <= rd_mem(rom_addr[0]);
    v2_q <= rom_rd[1];
    a2_q <= rom_addr[1];
    if (v2_q) rom_data[1] <= rd_mem(a2_q);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt [2];
  int rd_first [2];
  int rd_last [2];
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rom_rd[u] === 1'b1) begin
        if (rd_cnt[u] == 0) rd_first[u] = int'(rom_addr[u]);
        rd_last[u] = int'(rom_addr[u]);
        rd_cnt[u]  = rd_cnt[u] + 1;
      end
    end
  end

  int         n_chk = 0;
  int         n_err = 0;
  logic [3:0] exp_blk [2];
  int         exp_rr [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int r = 0; r < HEIGHT; r++) mem[r] = '0;
  endtask

  // Reference: what a probe must report, how many rows it reads and when done appears
  // (cycles after the grant cycle), from the probe geometry alone.
  function automatic void model(input int d, input int x, input int y, input int lat_rom,
                                output bit blk, output int lat, output int nrd, output int a0);
    int row;
    int col;
    blk = 1'b1; lat = 1; nrd = 0; a0 = 0;
    if (d < 2) begin
      col = (d == 0) ? x - 1 : x + SIZE;
      if ((d == 0 && x == 0) || (d == 1 && x + SIZE >= WIDTH) || y >= HEIGHT) return;
      a0 = y;
      for (int k = 0; k < SIZE; k++) begin
        row = y + k;
        if (row >= HEIGHT) begin
          lat = 1 + k * (1 + lat_rom); nrd = k; return;
        end
        if (col >= WIDTH || mem[row][col]) begin
          lat = 1 + (k + 1) * (1 + lat_rom); nrd = k + 1; return;
        end
      end
      blk = 1'b0; nrd = SIZE; lat = 1 + SIZE * (1 + lat_rom);
    end else begin
      row = (d == 2) ? y - 1 : y + SIZE;
      if ((d == 2 && y == 0) || row >= HEIGHT) return;
      a0 = row; nrd = 1; lat = 2 + lat_rom; blk = 1'b0;
      for (int c = x; c < x + SIZE; c++)
        if (c >= WIDTH || mem[row][c]) blk = 1'b1;
    end
  endfunction

  function automatic int arb(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic run_probe(input int u, input int d, input int x, input int y, input string tag);
    bit         eb;
    int         el, en, ea, t0, lat;
    logic [3:0] dn;
    model(d, x, y, u + 1, eb, el, en, ea);
    @(negedge clk);
    bx[u] = 10'(x); by[u] = 10'(y); req[u] = 4'b0001 << d;
    rd_cnt[u] = 0; rd_first[u] = -1; rd_last[u] = -1;
    t0 = cyc; lat = -1; dn = '0;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      @(negedge clk);
      if (done[u] !== 4'b0000) begin
        lat = cyc - t0; dn = done[u];
      end
    end
    req[u] = 4'b0000;
    exp_blk[u][d] = eb;
    exp_rr[u] = (d + 1) % 4;
    check_eq({tag, " done"}, 32'(dn), 32'(4'b0001 << d));
    check_eq({tag, " latency"}, lat, el);
    check_eq({tag, " blocked"}, 32'(blocked[u]), 32'(exp_blk[u]));
    check_eq({tag, " reads"}, rd_cnt[u], en);
    if (en > 0) begin
      check_eq({tag, " first addr"}, rd_first[u], ea);
      check_eq({tag, " last addr"}, rd_last[u], ea + en - 1);
    end
    @(negedge clk);
    check_eq({tag, " idle after"}, {done[u], busy[u]}, 5'b00000);
  endtask

  task automatic run_arb(input int u, input int n, input logic [3:0] r0, input bit rnd,
                         input int x, input int y, input string tag);
    logic [3:0] r;
    int         g, el, en, ea, wn;
    bit         eb;
    r = r0;
    @(negedge clk);
    bx[u] = 10'(x); by[u] = 10'(y); req[u] = r;
    for (int i = 0; i < n; i++) begin
      g = arb(r, exp_rr[u]);
      model(g, x, y, u + 1, eb, el, en, ea);
      wn = 0;
      do begin
        @(negedge clk);
        wn++;
      end while (done[u] === 4'b0000 && wn < 200);
      exp_blk[u][g] = eb;
      exp_rr[u] = (g + 1) % 4;
      check_eq({tag, " grant order"}, 32'(done[u]), 32'(4'b0001 << g));
      check_eq({tag, " blocked"}, 32'(blocked[u]), 32'(exp_blk[u]));
      if (rnd) begin
        r = r & ~(4'b0001 << g);
        r = r | 4'($urandom_range(0, 15));
        if (r == 4'b0000) r = 4'b0001 << $urandom_range(0, 3);
      end
      if (i == n - 1) r = 4'b0000;
      req[u] = r;
    end
    @(negedge clk);
    check_eq({tag, " idle after"}, {done[u], busy[u]}, 5'b00000);
  endtask

  function automatic int pick_coord(input int lim);
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return $urandom_range(1, 2);
      2:       return lim - SIZE - $urandom_range(0, 2);
      3:       return lim - $urandom_range(1, SIZE);
      default: return $urandom_range(0, lim - 1);
    endcase
  endfunction

  task automatic sprinkle_walls(input int x, input int y, input int n);
    int r, c;
    for (int j = 0; j < n; j++) begin
      r = y - 2 + $urandom_range(0, SIZE + 3);
      c = x - 2 + $urandom_range(0, SIZE + 3);
      if (r < 0) r = 0;
      if (r > HEIGHT - 1) r = HEIGHT - 1;
      if (c < 0) c = 0;
      if (c > WIDTH - 1) c = WIDTH - 1;
      mem[r][c] = 1'b1;
    end
  endtask

  initial begin
    int u, d, x, y;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = '0; bx[i] = '0; by[i] = '0;
      exp_blk[i] = '0; exp_rr[i] = 0; rd_cnt[i] = 0;
    end
    clear_mem();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("reset done", 32'(done[i]), 32'd0);
      check_eq("reset blocked", 32'(blocked[i]), 32'd0);
      check_eq("reset busy", 32'(busy[i]), 32'd0);
      check_eq("reset rom_rd", 32'(rom_rd[i]), 32'd0);
      check_eq("reset rom_addr", 32'(rom_addr[i]), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      clear_mem();
      run_probe(i, 0, 100, 100, "left full scan");
      mem[105][99] = 1'b1;
      run_probe(i, 0, 100, 100, "left hit row5");
      clear_mem();
      run_probe(i, 0, 0, 200, "left edge x0");
      run_probe(i, 3, 300, 464, "down edge");
      run_probe(i, 2, 300, 0, "up edge");
      run_probe(i, 1, 624, 100, "right edge");
      mem[103][639] = 1'b1;
      run_probe(i, 1, 623, 100, "right last col");
      run_probe(i, 3, 300, 463, "down last row");
      run_probe(i, 0, 200, 470, "left past bottom");
      mem[49][639] = 1'b1;
      run_probe(i, 2, 624, 50, "up corner hit");
      run_probe(i, 2, 630, 60, "up past width");
      clear_mem();
      run_arb(i, 8, 4'b1111, 1'b0, 100, 100, "rr all held");
    end

    run_probe(0, 1, 630, 100, "pre reset right edge");
    @(negedge clk);
    bx[0] = 10'd100; by[0] = 10'd100; req[0] = 4'b0001;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req[0] = 4'b0000;
    check_eq("mid reset done", 32'(done[0]), 32'd0);
    check_eq("mid reset rom_rd", 32'(rom_rd[0]), 32'd0);
    check_eq("mid reset busy", 32'(busy[0]), 32'd0);
    check_eq("mid reset blocked", 32'(blocked[0]), 32'd0);
    exp_blk[0] = '0; exp_rr[0] = 0;
    exp_blk[1] = '0; exp_rr[1] = 0;
    run_arb(0, 4, 4'b1110, 1'b0, 0, 0, "post reset rr");
    run_arb(0, 1, 4'b1111, 1'b0, 0, 0, "post reset wrap");

    for (int it = 0; it < 60; it++) begin
      u = $urandom_range(0, 1);
      d = $urandom_range(0, 3);
      x = pick_coord(WIDTH);
      y = pick_coord(HEIGHT);
      clear_mem();
      sprinkle_walls(x, y, $urandom_range(0, 4));
      run_probe(u, d, x, y, "random probe");
    end

    for (int it = 0; it < 4; it++) begin
      u = it % 2;
      x = pick_coord(WIDTH);
      y = pick_coord(HEIGHT);
      clear_mem();
      sprinkle_walls(x, y, $urandom_range(0, 6));
      run_arb(u, 12, 4'($urandom_range(1, 15)), 1'b1, x, y, "random arb");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
